// File: rtl/rsa_edge_feeder.sv
// rsa_edge_feeder
//   Transmit side of the PE_MAC systolic edge. One job of k_len operand
//   beats is buffered, then streamed to the array edge without any bubble.
//   Each lane is skewed by its index, and PE_mode is held for the whole job.
//
// Ports
//   clk, sys_rst_n         clock, asynchronous active-low reset
//   start, k_len, mode_in  job request (sampled in IDLE only)
//   in_valid, in_ready     operand beat handshake
//   in_h, in_v             operand beat: ROW h lanes, COL v lanes
//   PE_mode                mode broadcast to every PE, held for the job
//   h_data_out             per-row edge data, lane r delayed r cycles
//   v_data_out             per-column edge data, lane c delayed c cycles
//   cal_en_out             per-column cal_en, lane c delayed c cycles
//   cal_done_out           per-column cal_done, lane c delayed c cycles
//   busy                   high in every state except IDLE
//   done                   1-cycle pulse once the results have drained
//   err                    1-cycle pulse when a start is rejected
module rsa_edge_feeder #(
  parameter int RSA_DW = 16,
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int K_MAX  = 16,
  parameter int KW     = 5
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic [1:0]            mode_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROW*RSA_DW-1:0] in_h,
  input  logic [COL*RSA_DW-1:0] in_v,
  output logic [1:0]            PE_mode,
  output logic [ROW*RSA_DW-1:0] h_data_out,
  output logic [COL*RSA_DW-1:0] v_data_out,
  output logic [COL-1:0]        cal_en_out,
  output logic [COL-1:0]        cal_done_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW      = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int DRAIN_N = ROW + 2 * COL;
  localparam int DCW     = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t              state;
  logic [KW-1:0]       k_reg;
  logic [KW-1:0]       wr_ptr;
  logic [KW-1:0]       rd_cnt;
  logic [DCW-1:0]      dcnt;

  logic [ROW*RSA_DW-1:0] buf_h [K_MAX];
  logic [COL*RSA_DW-1:0] buf_v [K_MAX];

  logic handshake;
  logic k_ok;

  assign handshake = in_valid & in_ready;
  assign k_ok      = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign busy      = (state != IDLE);

  // Control FSM
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      k_reg    <= '0;
      wr_ptr   <= '0;
      rd_cnt   <= '0;
      dcnt     <= '0;
      in_ready <= 1'b0;
      PE_mode  <= 2'b00;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k_ok) begin
              k_reg    <= k_len;
              PE_mode  <= mode_in;
              wr_ptr   <= '0;
              in_ready <= 1'b1;
              state    <= FILL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FILL: begin
          if (handshake) begin
            wr_ptr <= wr_ptr + KW'(1);
            if (wr_ptr == k_reg - KW'(1)) begin
              in_ready <= 1'b0;
              rd_cnt   <= '0;
              state    <= STREAM;
            end
          end
        end
        STREAM: begin
          // k_reg beats plus one cal_done cycle
          if (rd_cnt == k_reg) begin
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + KW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DCW'(DRAIN_N - 1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand buffer: data only, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (state == FILL && handshake) begin
      buf_h[wr_ptr[AW-1:0]] <= in_h;
      buf_v[wr_ptr[AW-1:0]] <= in_v;
    end
  end

  // Stage p0: unskewed lane-0 values, zero outside STREAM so skew lines flush
  logic                  beat_p0;
  logic                  en_p0;
  logic                  dn_p0;
  logic [ROW*RSA_DW-1:0] h_p0;
  logic [COL*RSA_DW-1:0] v_p0;

  assign beat_p0 = (state == STREAM) && (rd_cnt < k_reg);
  assign en_p0   = beat_p0;
  assign dn_p0   = (state == STREAM) && (rd_cnt == k_reg);
  assign h_p0    = beat_p0 ? buf_h[rd_cnt[AW-1:0]] : '0;
  assign v_p0    = beat_p0 ? buf_v[rd_cnt[AW-1:0]] : '0;

  // Skew stages: row lane r sees stage p0 delayed r cycles
  for (genvar r = 0; r < ROW; r++) begin : g_h
    if (r == 0) begin : g_direct
      assign h_data_out[0 +: RSA_DW] = h_p0[0 +: RSA_DW];
    end else begin : g_skew
      logic [RSA_DW-1:0] sr [r];
      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          for (int j = 0; j < r; j++) sr[j] <= '0;
        end else begin
          sr[0] <= h_p0[r*RSA_DW +: RSA_DW];
          for (int j = 1; j < r; j++) sr[j] <= sr[j-1];
        end
      end
      assign h_data_out[r*RSA_DW +: RSA_DW] = sr[r-1];
    end
  end

  // Skew stages: column lane c carries {data, cal_en, cal_done} delayed c cycles
  for (genvar c = 0; c < COL; c++) begin : g_v
    if (c == 0) begin : g_direct
      assign v_data_out[0 +: RSA_DW] = v_p0[0 +: RSA_DW];
      assign cal_en_out[0]           = en_p0;
      assign cal_done_out[0]         = dn_p0;
    end else begin : g_skew
      logic [RSA_DW+1:0] sr [c];
      always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          for (int j = 0; j < c; j++) sr[j] <= '0;
        end else begin
          sr[0] <= {v_p0[c*RSA_DW +: RSA_DW], en_p0, dn_p0};
          for (int j = 1; j < c; j++) sr[j] <= sr[j-1];
        end
      end
      assign v_data_out[c*RSA_DW +: RSA_DW] = sr[c-1][RSA_DW+1:2];
      assign cal_en_out[c]                  = sr[c-1][1];
      assign cal_done_out[c]                = sr[c-1][0];
    end
  end

endmodule

// File: tb/tb_rsa_edge_feeder.sv
module tb_rsa_edge_feeder;

  localparam int DW      = 16;
  localparam int ROW     = 4;
  localparam int COL     = 4;
  localparam int K_MAX   = 16;
  localparam int KW      = 5;
  localparam int DRAIN_N = ROW + 2 * COL;

  logic               clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic [1:0]         mode_in = 2'b00;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [ROW*DW-1:0]  in_h = '0;
  logic [COL*DW-1:0]  in_v = '0;
  logic [1:0]         PE_mode;
  logic [ROW*DW-1:0]  h_data_out;
  logic [COL*DW-1:0]  v_data_out;
  logic [COL-1:0]     cal_en_out;
  logic [COL-1:0]     cal_done_out;
  logic               busy;
  logic               done;
  logic               err;

  rsa_edge_feeder #(.RSA_DW(DW), .ROW(ROW), .COL(COL), .K_MAX(K_MAX), .KW(KW)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .k_len(k_len),
    .mode_in(mode_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_h(in_h), .in_v(in_v), .PE_mode(PE_mode), .h_data_out(h_data_out),
    .v_data_out(v_data_out), .cal_en_out(cal_en_out),
    .cal_done_out(cal_done_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [1:0] last_mode = 2'b00;

  typedef struct {
    int         k;
    logic [1:0] mode;
    logic [4:0] pat;     // in_valid pattern during FILL, bit 0 first
    int         base;
    bit         poke;    // drive start/mode_in changes while busy
    int         rst_t;   // stream cycle at which reset is pulsed, -1 none
    bit         exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hval(int base, int i, int r);
    return 16'(base + i + 256 * r);
  endfunction

  function automatic logic [15:0] vval(int base, int i, int c);
    return 16'(32768 + base + i + 256 * c);
  endfunction

  task automatic exp_lanes(input int t, input int k, input int base,
                           output logic [63:0] he, output logic [63:0] ve,
                           output logic [3:0] ee, output logic [3:0] de);
    he = '0; ve = '0; ee = '0; de = '0;
    for (int r = 0; r < ROW; r++)
      if (t - r >= 0 && t - r < k) he[r*DW +: DW] = hval(base, t - r, r);
    for (int c = 0; c < COL; c++) begin
      if (t - c >= 0 && t - c < k) begin
        ve[c*DW +: DW] = vval(base, t - c, c);
        ee[c] = 1'b1;
      end else if (t - c == k) begin
        de[c] = 1'b1;
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " h"}, h_data_out, '0);
    chk({tag, " v"}, v_data_out, '0);
    chk({tag, " ctl"}, {cal_en_out, cal_done_out, in_ready, busy}, '0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc;
    int cyc;
    logic rdy;
    logic [63:0] he, ve;
    logic [3:0] ee, de;
    string tag;
    int t_done;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    start = 1'b1; k_len = KW'(v.k); mode_in = v.mode;
    @(posedge clk);
    if (v.exp_err) begin
      @(negedge clk);
      start = 1'b0;
      chk({tag, " err pulse"}, err, 1'b1);
      chk_quiet({tag, " rejected"});
      chk({tag, " mode kept"}, PE_mode, last_mode);
      @(negedge clk);
      chk({tag, " err clear"}, {err, busy}, 2'b00);
      return;
    end
    acc = 0; cyc = 0;
    while (acc < v.k && cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) begin
        chk({tag, " fill busy/ready"}, {busy, in_ready}, 2'b11);
        chk({tag, " fill mode"}, PE_mode, v.mode);
      end
      in_valid = v.pat[cyc % 5];
      for (int r = 0; r < ROW; r++) in_h[r*DW +: DW] = in_valid ? hval(v.base, acc, r) : 16'hDEAD;
      for (int c = 0; c < COL; c++) in_v[c*DW +: DW] = in_valid ? vval(v.base, acc, c) : 16'hBEEF;
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) acc++;
      cyc++;
    end
    chk({tag, " beats accepted"}, 64'(acc), 64'(v.k));
    if (acc != v.k) begin
      in_valid = 1'b0;
      return;
    end
    last_mode = v.mode;
    t_done = v.k + 1 + DRAIN_N;
    for (int t = 0; t <= t_done; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_h = {ROW{16'hDEAD}};
      in_v = {COL{16'hBEEF}};
      if (t == 0) chk({tag, " ready low in stream"}, in_ready, 1'b0);
      if (v.poke) begin
        start = (t >= 1 && t <= 3);
        mode_in = ~v.mode;
        k_len = KW'(4);
      end
      if (t == v.rst_t) begin
        sys_rst_n = 1'b0;
        #1;
        chk_quiet({tag, " async reset"});
        chk({tag, " reset flags"}, {PE_mode, done, err}, '0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        in_valid = 1'b0;
        last_mode = 2'b00;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          chk({tag, $sformatf(" post-reset idle c%0d", j)}, {done, busy, cal_en_out}, '0);
        end
        return;
      end
      exp_lanes(t, v.k, v.base, he, ve, ee, de);
      chk({tag, $sformatf(" h t%0d", t)}, h_data_out, he);
      chk({tag, $sformatf(" v t%0d", t)}, v_data_out, ve);
      chk({tag, $sformatf(" en/done t%0d", t)}, {cal_en_out, cal_done_out}, {ee, de});
      chk({tag, $sformatf(" done t%0d", t)}, done, (t == t_done));
      chk({tag, $sformatf(" busy t%0d", t)}, busy, (t < t_done));
      chk({tag, $sformatf(" mode t%0d", t)}, PE_mode, v.mode);
      chk({tag, $sformatf(" err t%0d", t)}, err, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    chk({tag, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{k:0,  mode:2'b00, pat:5'b11111, base:0,   poke:0, rst_t:-1, exp_err:1};
    vecs[1] = '{k:17, mode:2'b01, pat:5'b11111, base:0,   poke:0, rst_t:-1, exp_err:1};
    vecs[2] = '{k:3,  mode:2'b00, pat:5'b11111, base:1,   poke:0, rst_t:-1, exp_err:0};
    vecs[3] = '{k:3,  mode:2'b01, pat:5'b11001, base:20,  poke:0, rst_t:-1, exp_err:0};
    vecs[4] = '{k:16, mode:2'b10, pat:5'b11111, base:1,   poke:0, rst_t:-1, exp_err:0};
    vecs[5] = '{k:2,  mode:2'b11, pat:5'b10101, base:100, poke:1, rst_t:-1, exp_err:0};
    vecs[6] = '{k:31, mode:2'b10, pat:5'b11111, base:0,   poke:0, rst_t:-1, exp_err:1};
    vecs[7] = '{k:1,  mode:2'b01, pat:5'b11111, base:7,   poke:0, rst_t:-1, exp_err:0};
    vecs[8] = '{k:4,  mode:2'b11, pat:5'b11111, base:50,  poke:0, rst_t:2,  exp_err:0};
    vecs[9] = '{k:3,  mode:2'b10, pat:5'b01111, base:9,   poke:0, rst_t:-1, exp_err:0};

    repeat (3) @(negedge clk);
    chk_quiet("in reset");
    chk("in reset flags", {PE_mode, done, err}, '0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("after reset");
    chk("after reset flags", {PE_mode, done, err}, '0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
